jtkcpu_regs: RTL and testbench

//  Programmer-visible register file of the KCPU core: A, B (D=A:B), X, Y, U, S, DP, CC.
//  - Upstream of the ALU: selects its opnd0 source.
//  - Downstream of the ALU: writes back rslt, rslt_hi (LMUL) and cc_out.
//  - Also executes TFR/EXG and push/pull stack-pointer stepping.
//  - Tracks NMI arming.

---
 rtl/jtkcpu_regs.sv | 153 +++++++++++++++
 tb/tb_jtkcpu_regs.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_regs.sv
// KCPU programmer-visible register file: operand select, ALU write-back, TFR/EXG, stack stepping.
// Optional macro JTKCPU_NMI_ARM_EN enables NMI arming on the first S write; otherwise nmi_armed is 1.
module jtkcpu_regs #(
  parameter logic [7:0]  RST_CC = 8'h50,
  parameter logic [15:0] RST_S  = 16'h0
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [3:0]  opnd0_sel,
  output logic [15:0] opnd0,
  input  logic [15:0] rslt,
  input  logic [15:0] rslt_hi,
  input  logic [7:0]  cc_alu,
  input  logic [3:0]  dst_sel,
  input  logic        we,
  input  logic        we_cc,
  input  logic        we_lmul,
  input  logic        xfr_exg,
  input  logic        xfr_tfr,
  input  logic        stk_u,
  input  logic        stk_inc,
  input  logic        stk_dec,
  input  logic [1:0]  stk_amt,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  dp,
  output logic [7:0]  cc,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] u,
  output logic [15:0] s,
  output logic        nmi_armed
);

  function automatic logic [15:0] rd(input logic [3:0] sel,
                                     input logic [7:0] ra, rb, rdp, rcc,
                                     input logic [15:0] rx, ry, ru, rs);
    case (sel)
      4'd0:    rd = {8'h00, ra};
      4'd1:    rd = {8'h00, rb};
      4'd2:    rd = rx;
      4'd3:    rd = ry;
      4'd4:    rd = rs;
      4'd5:    rd = ru;
      4'd6:    rd = {8'h00, rcc};
      4'd7:    rd = {8'h00, rdp};
      4'd8:    rd = {ra, rb};
      default: rd = 16'h0000;
    endcase
  endfunction

  logic [15:0] dst_val;
  logic [7:0]  n_a, n_b, n_dp, n_cc;
  logic [15:0] n_x, n_y, n_u, n_s;
  logic [15:0] step;
  logic [3:0]  wsel [3];
  logic [15:0] wval [3];
  logic        wen  [3];

  assign opnd0   = rd(opnd0_sel, a, b, dp, cc, x, y, u, s);
  assign dst_val = rd(dst_sel,   a, b, dp, cc, x, y, u, s);
  assign step    = (stk_amt == 2'd2) ? 16'd2 : 16'd1;

  // Write ports in ascending priority: ALU write-back, transfer into dst, EXG back into opnd0_sel.
  assign wen[0]  = we;
  assign wsel[0] = dst_sel;
  assign wval[0] = rslt;
  assign wen[1]  = xfr_exg | xfr_tfr;
  assign wsel[1] = dst_sel;
  assign wval[1] = opnd0;
  assign wen[2]  = xfr_exg;
  assign wsel[2] = opnd0_sel;
  assign wval[2] = dst_val;

  always_comb begin
    n_a  = a;
    n_b  = b;
    n_dp = dp;
    n_cc = cc;
    n_x  = x;
    n_y  = y;
    n_u  = u;
    n_s  = s;
    if (stk_inc ^ stk_dec) begin
      if (stk_u) n_u = stk_inc ? u + step : u - step;
      else       n_s = stk_inc ? s + step : s - step;
    end
    if (we_cc) n_cc = cc_alu;
    for (int k = 0; k < 3; k++) begin
      if (k == 1 && we_lmul) begin
        n_x = rslt_hi;
        n_y = rslt;
      end
      if (wen[k]) begin
        case (wsel[k])
          4'd0: n_a  = wval[k][7:0];
          4'd1: n_b  = wval[k][7:0];
          4'd2: n_x  = wval[k];
          4'd3: n_y  = wval[k];
          4'd4: n_s  = wval[k];
          4'd5: n_u  = wval[k];
          4'd6: n_cc = wval[k][7:0];
          4'd7: n_dp = wval[k][7:0];
          4'd8: begin
            n_a = wval[k][15:8];
            n_b = wval[k][7:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a  <= 8'h00;
      b  <= 8'h00;
      dp <= 8'h00;
      cc <= RST_CC;
      x  <= 16'h0000;
      y  <= 16'h0000;
      u  <= 16'h0000;
      s  <= RST_S;
    end else if (cen) begin
      a  <= n_a;
      b  <= n_b;
      dp <= n_dp;
      cc <= n_cc;
      x  <= n_x;
      y  <= n_y;
      u  <= n_u;
      s  <= n_s;
    end
  end

`ifdef JTKCPU_NMI_ARM_EN
  logic s_wr;

  // Only explicit loads of S arm NMI; stack stepping does not.
  assign s_wr = (we && dst_sel == 4'd4) ||
                ((xfr_exg || xfr_tfr) && dst_sel == 4'd4) ||
                (xfr_exg && opnd0_sel == 4'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                nmi_armed <= 1'b0;
    else if (cen && s_wr)   nmi_armed <= 1'b1;
  end
`else
  assign nmi_armed = 1'b1;
`endif

endmodule

// File: tb/tb_jtkcpu_regs.sv
// Directed table-driven bench for jtkcpu_regs; state carries from one vector to the next.
module tb_jtkcpu_regs;

  logic        rst, clk, cen;
  logic [3:0]  opnd0_sel, dst_sel;
  logic [15:0] opnd0, rslt, rslt_hi;
  logic [7:0]  cc_alu;
  logic        we, we_cc, we_lmul, xfr_exg, xfr_tfr, stk_u, stk_inc, stk_dec;
  logic [1:0]  stk_amt;
  logic [7:0]  a, b, dp, cc;
  logic [15:0] x, y, u, s;
  logic        nmi_armed;

  int checks = 0;
  int errors = 0;

  jtkcpu_regs dut (
    .rst(rst), .clk(clk), .cen(cen), .opnd0_sel(opnd0_sel), .opnd0(opnd0),
    .rslt(rslt), .rslt_hi(rslt_hi), .cc_alu(cc_alu), .dst_sel(dst_sel),
    .we(we), .we_cc(we_cc), .we_lmul(we_lmul), .xfr_exg(xfr_exg), .xfr_tfr(xfr_tfr),
    .stk_u(stk_u), .stk_inc(stk_inc), .stk_dec(stk_dec), .stk_amt(stk_amt),
    .a(a), .b(b), .dp(dp), .cc(cc), .x(x), .y(y), .u(u), .s(s), .nmi_armed(nmi_armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cen, we, wcc, lmul, exg, tfr, su, inc, dec;
    logic [1:0]  amt;
    logic [3:0]  osel, dsel;
    logic [15:0] rslt, rhi;
    logic [7:0]  ccalu;
    logic [7:0]  ea, eb;
    logic [15:0] ex, ey, eu, es;
    logic [7:0]  edp, ecc;
    logic        enmi;
    logic [15:0] eop;
  } vec_t;

  vec_t vec [24];

  function automatic logic exp_nmi(input logic armed);
`ifdef JTKCPU_NMI_ARM_EN
    return armed;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    cen = 1'b1; we = 1'b0; we_cc = 1'b0; we_lmul = 1'b0; xfr_exg = 1'b0; xfr_tfr = 1'b0;
    stk_u = 1'b0; stk_inc = 1'b0; stk_dec = 1'b0; stk_amt = 2'd0;
    opnd0_sel = 4'd0; dst_sel = 4'd0; rslt = 16'h0; rslt_hi = 16'h0; cc_alu = 8'h0;
  endtask

  initial begin
    //         cen  we   wcc  lmul exg  tfr  su   inc  dec  amt osel dsel rslt      rhi       ccalu   a      b      x         y         u         s         dp     cc     nmi  op
    vec[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,4'd8,16'h1234,16'h0000,8'h00, 8'h12,8'h34,16'h0000,16'h0000,16'h0000,16'h0000,8'h00,8'h50,1'b0,16'h0012};
    vec[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd3,4'd2,16'hBEEF,16'hDEAD,8'h00, 8'h12,8'h34,16'hDEAD,16'hBEEF,16'h0000,16'h0000,8'h00,8'h50,1'b0,16'hBEEF};
    vec[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd0,4'd0,16'h0080,16'h0000,8'h00, 8'h80,8'h34,16'hDEAD,16'hBEEF,16'h0000,16'h0000,8'h00,8'h50,1'b0,16'h0080};
    vec[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd2,4'd2,16'h1234,16'h0000,8'h00, 8'h80,8'h34,16'h1234,16'hBEEF,16'h0000,16'h0000,8'h00,8'h50,1'b0,16'h1234};
    vec[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,4'd2,4'd0,16'h0000,16'h0000,8'h00, 8'h34,8'h34,16'h0080,16'hBEEF,16'h0000,16'h0000,8'h00,8'h50,1'b0,16'h0080};
    vec[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,4'd6,4'd8,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0000,16'h0000,8'h00,8'h50,1'b0,16'h0050};
    vec[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd1,4'd4,4'd0,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0000,16'h0001,8'h00,8'h50,1'b0,16'h0001};
    vec[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,4'd4,4'd0,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0000,16'hFFFF,8'h00,8'h50,1'b0,16'hFFFF};
    vec[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'd2,4'd4,4'd0,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0000,16'hFFFF,8'h00,8'h50,1'b0,16'hFFFF};
    vec[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,4'd4,4'd0,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0000,16'h0001,8'h00,8'h50,1'b0,16'h0001};
    vec[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd3,4'd5,4'd0,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0001,16'h0001,8'h00,8'h50,1'b0,16'h0001};
    vec[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'd0,4'd5,4'd0,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0000,16'h0001,8'h00,8'h50,1'b0,16'h0000};
    vec[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'd1,4'd5,4'd0,16'h0000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'hFFFF,16'h0001,8'h00,8'h50,1'b0,16'hFFFF};
    vec[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd6,4'd0,16'h0000,16'h0000,8'hAB, 8'h00,8'h50,16'h0080,16'hBEEF,16'hFFFF,16'h0001,8'h00,8'hAB,1'b0,16'h00AB};
    vec[14] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd6,4'd6,16'h00C3,16'h0000,8'h11, 8'h00,8'h50,16'h0080,16'hBEEF,16'hFFFF,16'h0001,8'h00,8'hC3,1'b0,16'h00C3};
    vec[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd1,4'd5,4'd5,16'h4444,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h4444,16'h0001,8'h00,8'hC3,1'b0,16'h4444};
    vec[16] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,4'd2,4'd5,16'h9999,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0080,16'h0001,8'h00,8'hC3,1'b0,16'h0080};
    vec[17] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd4,4'd4,16'h2000,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0080,16'h2000,8'h00,8'hC3,1'b1,16'h2000};
    vec[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd1,4'd4,4'd4,16'h3333,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0080,16'h2000,8'h00,8'hC3,1'b1,16'h2000};
    vec[19] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd9,4'd9,16'hFFFF,16'h0000,8'h00, 8'h00,8'h50,16'h0080,16'hBEEF,16'h0080,16'h2000,8'h00,8'hC3,1'b1,16'h0000};
    vec[20] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,4'd1,4'd0,16'h0000,16'h0000,8'h00, 8'h50,8'h00,16'h0080,16'hBEEF,16'h0080,16'h2000,8'h00,8'hC3,1'b1,16'h0000};
    vec[21] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,4'd2,4'd2,16'h0000,16'h0000,8'h00, 8'h50,8'h00,16'h0080,16'hBEEF,16'h0080,16'h2000,8'h00,8'hC3,1'b1,16'h0080};
    vec[22] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,4'd3,4'd7,16'h0000,16'h0000,8'h00, 8'h50,8'h00,16'h0080,16'hBEEF,16'h0080,16'h2000,8'hEF,8'hC3,1'b1,16'hBEEF};
    vec[23] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'd8,4'd8,16'h1111,16'h2222,8'h00, 8'h11,8'h11,16'h2222,16'h1111,16'h0080,16'h2000,8'hEF,8'hC3,1'b1,16'h1111};

    idle();
    rst = 1'b1;
    opnd0_sel = 4'd8;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_s", s, 16'h0000);
    chk("rst_cc", {8'h00, cc}, 16'h0050);
    chk("rst_nmi", {15'h0, nmi_armed}, {15'h0, exp_nmi(1'b0)});
    chk("rst_opnd0_d", opnd0, 16'h0000);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cen = vec[i].cen; we = vec[i].we; we_cc = vec[i].wcc; we_lmul = vec[i].lmul;
      xfr_exg = vec[i].exg; xfr_tfr = vec[i].tfr; stk_u = vec[i].su;
      stk_inc = vec[i].inc; stk_dec = vec[i].dec; stk_amt = vec[i].amt;
      opnd0_sel = vec[i].osel; dst_sel = vec[i].dsel;
      rslt = vec[i].rslt; rslt_hi = vec[i].rhi; cc_alu = vec[i].ccalu;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a", i), {8'h00, a}, {8'h00, vec[i].ea});
      chk($sformatf("v%0d_b", i), {8'h00, b}, {8'h00, vec[i].eb});
      chk($sformatf("v%0d_x", i), x, vec[i].ex);
      chk($sformatf("v%0d_y", i), y, vec[i].ey);
      chk($sformatf("v%0d_u", i), u, vec[i].eu);
      chk($sformatf("v%0d_s", i), s, vec[i].es);
      chk($sformatf("v%0d_dp", i), {8'h00, dp}, {8'h00, vec[i].edp});
      chk($sformatf("v%0d_cc", i), {8'h00, cc}, {8'h00, vec[i].ecc});
      chk($sformatf("v%0d_nmi", i), {15'h0, nmi_armed}, {15'h0, exp_nmi(vec[i].enmi)});
      chk($sformatf("v%0d_opnd0", i), opnd0, vec[i].eop);
    end

    // Asynchronous reset between clock edges clears everything at once.
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_a", {8'h00, a}, 16'h0000);
    chk("arst_x", x, 16'h0000);
    chk("arst_s", s, 16'h0000);
    chk("arst_cc", {8'h00, cc}, 16'h0050);
    chk("arst_nmi", {15'h0, nmi_armed}, {15'h0, exp_nmi(1'b0)});

    // Writes requested while reset is held are discarded.
    we = 1'b1; dst_sel = 4'd8; rslt = 16'h5A5A;
    @(posedge clk);
    #1;
    chk("rsthold_a", {8'h00, a}, 16'h0000);
    chk("rsthold_nmi", {15'h0, nmi_armed}, {15'h0, exp_nmi(1'b0)});

    // TFR into S arms NMI even when the transferred value is unchanged.
    @(negedge clk);
    rst = 1'b0;
    idle();
    xfr_tfr = 1'b1; opnd0_sel = 4'd0; dst_sel = 4'd4;
    @(posedge clk);
    #1;
    chk("tfr_s", s, 16'h0000);
    chk("tfr_nmi", {15'h0, nmi_armed}, {15'h0, exp_nmi(1'b1)});

    // Stack-only activity after reset leaves NMI disarmed.
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    idle();
    stk_inc = 1'b1; stk_amt = 2'd2;
    @(posedge clk);
    #1;
    chk("stk_s", s, 16'h0002);
    chk("stk_nmi", {15'h0, nmi_armed}, {15'h0, exp_nmi(1'b0)});

    @(negedge clk);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
